// File: rtl/mbist_march_engine_if.sv
// Memory-side bus of the MBIST March engine: one access strobe per cycle,
// read data returned exactly one cycle after a read strobe.
interface mbist_march_engine_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_en, output mem_we, output mem_addr, output mem_wdata,
                    input mem_rdata);
    modport slave  (input mem_en, input mem_we, input mem_addr, input mem_wdata,
                    output mem_rdata);
endinterface

// File: rtl/mbist_march_engine.sv
// MBIST March engine: runs March C- or MATS+ over a memory, counts read
// mismatches and logs unique failing addresses into spare rows for repair.
module mbist_march_engine #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int NUM_SPARES = 2,
    parameter int FCNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         alg_sel,
    mbist_march_engine_if.master         mem,
    output logic                         busy,
    output logic                         done,
    output logic                         fail,
    output logic [FCNT_W-1:0]            fail_count,
    output logic [NUM_SPARES-1:0]        spare_valid,
    output logic [NUM_SPARES*ADDR_W-1:0] spare_addr,
    output logic                         repairable
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    function automatic logic [2:0] last_elem(input logic alg);
        return alg ? 3'd2 : 3'd5;
    endfunction

    function automatic logic two_ops(input logic alg, input logic [2:0] e);
        return (e != 3'd0) && !(!alg && e == 3'd5);
    endfunction

    function automatic logic elem_down(input logic alg, input logic [2:0] e);
        return alg ? (e == 3'd2) : (e == 3'd3 || e == 3'd4);
    endfunction

    // Value read first in an element; a following write stores its complement.
    function automatic logic read_val(input logic alg, input logic [2:0] e);
        return alg ? (e == 3'd2) : (e == 3'd2 || e == 3'd4);
    endfunction

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (&v) ? v : v + FCNT_W'(1);
    endfunction

    state_t                  state;
    logic                    alg_r;
    logic [2:0]              elem_c;
    logic [ADDR_W-1:0]       addr_c;
    logic                    opi_c;
    logic                    fin_c;
    logic                    overflow;

    logic                    en_p0;
    logic                    we_p0;
    logic [ADDR_W-1:0]       addr_p0;
    logic [DATA_W-1:0]       wdata_p0;
    logic [DATA_W-1:0]       exp_p0;

    logic                    vld_p1;
    logic [ADDR_W-1:0]       cmp_addr_p1;
    logic [DATA_W-1:0]       cmp_exp_p1;

    logic [2:0]              nxt_elem;
    logic [ADDR_W-1:0]       nxt_addr;
    logic                    nxt_opi;
    logic                    is_last;
    logic                    op_we;
    logic [DATA_W-1:0]       op_data;
    logic                    mis_p1;
    logic                    hit;
    logic                    take;
    logic [NUM_SPARES-1:0]   alloc_oh;

    assign mem.mem_en    = en_p0;
    assign mem.mem_we    = we_p0;
    assign mem.mem_addr  = addr_p0;
    assign mem.mem_wdata = wdata_p0;

    // Sequencer: the counters hold the next op to issue; is_last flags the final op.
    assign op_we   = (elem_c == 3'd0) || opi_c;
    assign op_data = {DATA_W{read_val(alg_r, elem_c) ^ opi_c}};

    always_comb begin
        nxt_elem = elem_c;
        nxt_addr = addr_c;
        nxt_opi  = 1'b0;
        is_last  = 1'b0;
        if (two_ops(alg_r, elem_c) && !opi_c) begin
            nxt_opi = 1'b1;
        end else if (addr_c != (elem_down(alg_r, elem_c) ? '0 : ADDR_MAX)) begin
            nxt_addr = elem_down(alg_r, elem_c) ? addr_c - ADDR_W'(1) : addr_c + ADDR_W'(1);
        end else if (elem_c != last_elem(alg_r)) begin
            nxt_elem = elem_c + 3'd1;
            nxt_addr = elem_down(alg_r, elem_c + 3'd1) ? ADDR_MAX : '0;
        end else begin
            is_last = 1'b1;
        end
    end

    // Compare stage: read data arrives alongside the registered (addr, expected).
    assign mis_p1 = vld_p1 && (mem.mem_rdata != cmp_exp_p1);
    assign take   = mis_p1 && !hit;

    always_comb begin
        hit      = 1'b0;
        alloc_oh = '0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            if (spare_valid[i] && spare_addr[i*ADDR_W +: ADDR_W] == cmp_addr_p1) hit = 1'b1;
            if (!spare_valid[i] && alloc_oh == '0) alloc_oh[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cmp_addr_p1 <= addr_p0;
        cmp_exp_p1  <= exp_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            alg_r       <= 1'b0;
            elem_c      <= '0;
            addr_c      <= '0;
            opi_c       <= 1'b0;
            fin_c       <= 1'b0;
            overflow    <= 1'b0;
            en_p0       <= 1'b0;
            we_p0       <= 1'b0;
            addr_p0     <= '0;
            wdata_p0    <= '0;
            exp_p0      <= '0;
            vld_p1      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            fail_count  <= '0;
            spare_valid <= '0;
            spare_addr  <= '0;
            repairable  <= 1'b0;
        end else begin
            vld_p1 <= en_p0 && !we_p0;
            if (mis_p1) begin
                fail       <= 1'b1;
                fail_count <= sat_inc(fail_count);
            end
            for (int i = 0; i < NUM_SPARES; i++) begin
                if (take && alloc_oh[i]) begin
                    spare_valid[i]                  <= 1'b1;
                    spare_addr[i*ADDR_W +: ADDR_W] <= cmp_addr_p1;
                end
            end
            if (take && alloc_oh == '0) overflow <= 1'b1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RUN;
                        alg_r       <= alg_sel;
                        elem_c      <= '0;
                        addr_c      <= '0;
                        opi_c       <= 1'b0;
                        fin_c       <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        fail        <= 1'b0;
                        fail_count  <= '0;
                        spare_valid <= '0;
                        spare_addr  <= '0;
                        repairable  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (fin_c) begin
                        en_p0 <= 1'b0;
                        we_p0 <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        en_p0    <= 1'b1;
                        we_p0    <= op_we;
                        addr_p0  <= addr_c;
                        wdata_p0 <= op_data;
                        exp_p0   <= op_data;
                        if (is_last) begin
                            fin_c <= 1'b1;
                        end else begin
                            elem_c <= nxt_elem;
                            addr_c <= nxt_addr;
                            opi_c  <= nxt_opi;
                        end
                    end
                end
                S_DRAIN: begin
                    state      <= S_DONE;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    repairable <= !(overflow || (take && alloc_oh == '0));
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
